// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
// Imported by the fetch unit and its queue.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries.
// Flush has priority over push and pop.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  T              i_din,
    input  logic          i_pop,
    output T              o_dout,
    output logic [CW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = i_push & ~i_flush;
    assign w_pop  = i_pop & ~i_flush & (r_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= f_inc(r_wr);
            if (w_pop)  r_rd <= f_inc(r_rd);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    // Empty queue presents zeros so decode never sees stale entries.
    assign o_dout  = (r_count != '0) ? r_mem[r_rd] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests,
// queues responses for decode and handles redirects.
module fetch_unit #(
    parameter int              XLEN         = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              QDEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fetch_en,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [XLEN-1:0]              req_addr,
    input  logic                         rsp_valid,
    input  logic [riscv_pkg::INSTR_W-1:0] rsp_data,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [riscv_pkg::INSTR_W-1:0] out_instr
);

    import riscv_pkg::*;

    localparam int CW = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_used;
    logic            w_credit;
    logic            w_req_valid;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_target;
    logic [CW-1:0]   w_left;
    entry_t          w_din;
    entry_t          w_head;

    // Queued plus in-flight never exceeds QDEPTH, so pushes always fit.
    assign w_used      = {1'b0, r_inflight} + {1'b0, w_count};
    assign w_credit    = int'(w_used) < QDEPTH;
    assign w_req_valid = reset_n & fetch_en & ~redirect_valid & w_credit;
    assign w_issue     = w_req_valid & req_ready;
    assign w_push      = rsp_valid & (r_drop == '0) & ~redirect_valid;
    assign w_pop       = out_valid & out_ready;
    assign w_target    = {redirect_pc[XLEN-1:2], 2'b00};
    assign w_left      = r_inflight - CW'(rsp_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_VECTOR;
            r_resp_pc  <= RESET_VECTOR;
            r_inflight <= '0;
            r_drop     <= '0;
        end else if (redirect_valid) begin
            r_pc       <= w_target;
            r_resp_pc  <= w_target;
            r_inflight <= w_left;
            r_drop     <= w_left;
        end else begin
            if (w_issue) r_pc <= r_pc + XLEN'(PC_STEP);
            r_inflight <= r_inflight + CW'(w_issue) - CW'(rsp_valid);
            if (rsp_valid) begin
                if (r_drop != '0) r_drop <= r_drop - 1'b1;
                else r_resp_pc <= r_resp_pc + XLEN'(PC_STEP);
            end
        end
    end

    assign w_din.pc    = r_resp_pc;
    assign w_din.instr = rsp_data;

    fetch_queue #(
        .T     (entry_t),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_count (w_count)
    );

    assign req_valid = w_req_valid;
    assign req_addr  = r_pc;
    assign out_valid = (w_count != '0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

endmodule
